// File: rtl/packet_drain_if.sv
// packet_drain_if: upstream FIFO pop port plus downstream valid/ready word stream.
interface packet_drain_if #(parameter int WIDTH = 32);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [15:0]      pkt_count;
    modport master (
        input  fifo_empty, fifo_rd_data, out_ready,
        output fifo_rd_en, out_valid, out_data, out_last, pkt_count
    );
    modport slave (
        output fifo_empty, fifo_rd_data, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_last, pkt_count
    );
endinterface

// File: rtl/packet_drain.sv
// packet_drain: pops PKT_LEN words from a FIFO, streams them out, then appends
// their modulo-2^WIDTH sum as a checksum word flagged with out_last.
module packet_drain #(
    parameter int WIDTH   = 32,
    parameter int PKT_LEN = 4
) (
    input logic            clk,
    input logic            rst,
    packet_drain_if.master bus
);
    typedef enum logic [1:0] {FETCH, WAIT, SEND, CSUM} state_t;
    state_t           state;
    logic [WIDTH-1:0] sum;
    logic [7:0]       word_cnt;
    // Reset overrides the pop so nothing is lost from the FIFO while held in reset.
    assign bus.fifo_rd_en = !rst && state == FETCH && !bus.fifo_empty;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FETCH;
            sum           <= '0;
            word_cnt      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
            bus.pkt_count <= '0;
        end else begin
            case (state)
                FETCH: if (!bus.fifo_empty) state <= WAIT;
                WAIT: begin
                    bus.out_data  <= bus.fifo_rd_data;
                    bus.out_valid <= 1'b1;
                    state         <= SEND;
                end
                SEND: if (bus.out_ready) begin
                    sum      <= sum + bus.out_data;
                    word_cnt <= word_cnt + 8'd1;
                    if (word_cnt == 8'(PKT_LEN - 1)) begin
                        // Checksum includes the word being accepted right now.
                        bus.out_data <= sum + bus.out_data;
                        bus.out_last <= 1'b1;
                        state        <= CSUM;
                    end else begin
                        bus.out_valid <= 1'b0;
                        state         <= FETCH;
                    end
                end
                CSUM: if (bus.out_ready) begin
                    sum           <= '0;
                    word_cnt      <= '0;
                    bus.pkt_count <= bus.pkt_count + 16'd1;
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                    state         <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_drain.sv
// tb_packet_drain: randomized and directed checks of packet_drain against a
// transaction-level model (popped words -> expected payload/checksum stream).
module tb_packet_drain;
    localparam int W = 32;
    localparam int L = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    packet_drain_if #(.WIDTH(W)) bus();
    packet_drain #(.WIDTH(W), .PKT_LEN(L)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;
    int rel_cyc = 0;
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_d[$];
    bit exp_l[$];
    bit got_l[$];
    int rd_cyc[$];
    int acc_cyc[$];
    bit stall = 0;
    bit popped_prev = 0;
    bit vis = 0;
    logic [W-1:0] popped_word = '0;
    logic [W-1:0] m_sum = '0;
    int m_n = 0;
    logic [15:0] m_cnt = '0;
    logic [W-1:0] e1 [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10};
    logic [W-1:0] e3 [5] = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd26};
    logic [W-1:0] e5 [5] = '{32'd300, 32'd400, 32'd500, 32'd600, 32'd1800};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs at negedge, then compare DUT against the model.
    task automatic cycle(input bit r);
        @(negedge clk);
        cyc++;
        rst = r;
        bus.fifo_rd_data = (popped_prev && !r) ? popped_word : W'($urandom);
        bus.fifo_empty = stall || fifo_q.size() == 0;
        bus.out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : ($urandom_range(0, 99) < 60);
        #1;
        if (r) begin
            chk("rst_rd_en", bus.fifo_rd_en, 0);
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_last", bus.out_last, 0);
            chk("rst_data", bus.out_data, 0);
            chk("rst_pkt_count", bus.pkt_count, 0);
            exp_q.delete();
            exp_l.delete();
            m_sum = '0;
            m_n = 0;
            m_cnt = '0;
            popped_prev = 0;
            vis = 0;
        end else begin
            chk("rd_en", bus.fifo_rd_en, !bus.fifo_empty && !vis && !popped_prev);
            chk("out_valid", bus.out_valid, vis);
            chk("pkt_count", bus.pkt_count, m_cnt);
            if (vis && exp_q.size() > 0) begin
                chk("out_data", bus.out_data, exp_q[0]);
                chk("out_last", bus.out_last, exp_l[0]);
                if (bus.out_ready) begin
                    got_d.push_back(bus.out_data);
                    got_l.push_back(bus.out_last);
                    acc_cyc.push_back(cyc);
                    vis = !exp_l[0] && exp_q.size() > 1 && exp_l[1];
                    if (exp_l[0]) m_cnt++;
                    exp_q.pop_front();
                    exp_l.pop_front();
                end
            end
            if (popped_prev) vis = 1;
            popped_prev = bus.fifo_rd_en;
            if (bus.fifo_rd_en && fifo_q.size() > 0) begin
                popped_word = fifo_q.pop_front();
                rd_cyc.push_back(cyc);
                exp_q.push_back(popped_word);
                exp_l.push_back(1'b0);
                m_sum += popped_word;
                m_n++;
                if (m_n == L) begin
                    exp_q.push_back(m_sum);
                    exp_l.push_back(1'b1);
                    m_sum = '0;
                    m_n = 0;
                end
            end
        end
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        rd_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic wait_got(input int n, input string name);
        for (int i = 0; i < 80 && got_d.size() < n; i++) cycle(1'b0);
        chk(name, got_d.size() >= n, 1);
    endtask

    task automatic check_pkt(input logic [W-1:0] e [5], input string tag);
        chk({tag, "_words"}, got_d.size(), 5);
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            chk({tag, "_data"}, got_d[i], e[i]);
            chk({tag, "_last"}, got_l[i], i == 4);
        end
    endtask

    initial begin
        bus.fifo_empty = 1'b1;
        bus.out_ready = 1'b0;
        bus.fifo_rd_data = '0;
        cycle(1'b1);
        cycle(1'b1);
        // Basic packet 1,2,3,4 -> checksum 10, 13 cycles from first pop.
        clear_log();
        fifo_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        rel_cyc = cyc + 1;
        wait_got(5, "t1_done");
        cycle(1'b0);
        check_pkt(e1, "t1");
        chk("t1_pkt_count", bus.pkt_count, 1);
        if (rd_cyc.size() > 0 && acc_cyc.size() > 4) begin
            chk("t1_first_rd", rd_cyc[0], rel_cyc);
            chk("t1_cycles", acc_cyc[4] - rd_cyc[0] + 1, 13);
        end
        // Carry out of the checksum is dropped.
        clear_log();
        fifo_q = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};
        wait_got(5, "t2_done");
        cycle(1'b0);
        if (got_d.size() > 4) begin
            chk("t2_csum", got_d[4], 32'd1);
            chk("t2_last", got_l[4], 1);
        end
        chk("t2_pkt_count", bus.pkt_count, 2);
        // Backpressure on word 2.
        clear_log();
        fifo_q = '{32'd5, 32'd6, 32'd7, 32'd8};
        wait_got(1, "t3_first");
        ready_mode = 2;
        repeat (5) cycle(1'b0);
        chk("t3_hold_valid", bus.out_valid, 1);
        chk("t3_hold_data", bus.out_data, 32'd6);
        chk("t3_hold_rd", bus.fifo_rd_en, 0);
        ready_mode = 0;
        wait_got(5, "t3_done");
        check_pkt(e3, "t3");
        // FIFO empty between words 2 and 3.
        clear_log();
        fifo_q = '{32'd9, 32'd10, 32'd11, 32'd12};
        wait_got(2, "t4_two");
        stall = 1;
        repeat (10) cycle(1'b0);
        chk("t4_stall_rd", bus.fifo_rd_en, 0);
        chk("t4_stall_valid", bus.out_valid, 0);
        stall = 0;
        wait_got(5, "t4_done");
        if (got_d.size() > 4) chk("t4_csum", got_d[4], 32'd42);
        // Reset after two accepted words discards the partial packet.
        clear_log();
        fifo_q = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd500, 32'd600};
        wait_got(2, "t5_two");
        cycle(1'b1);
        clear_log();
        wait_got(5, "t5_done");
        cycle(1'b0);
        check_pkt(e5, "t5");
        chk("t5_pkt_count", bus.pkt_count, 1);
        // Random traffic, backpressure, stalls and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            stall = $urandom_range(0, 3) == 0;
            ready_mode = 1;
            if (fifo_q.size() < 4) fifo_q.push_back($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : W'($urandom));
            cycle($urandom_range(0, 599) == 0);
        end
        stall = 0;
        ready_mode = 0;
        repeat (40) cycle(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
